// File: rtl/parc_core_dpath_wb_arbiter_if.sv
// Long-latency result handshake into the writeback arbiter.
// master: mul/div result producer; slave: arbiter queue.
interface parc_core_dpath_wb_arbiter_if;
    logic        ll_val;
    logic        ll_rdy;
    logic [4:0]  ll_waddr;
    logic [31:0] ll_wdata;

    modport master (
        output ll_val,
        output ll_waddr,
        output ll_wdata,
        input  ll_rdy
    );

    modport slave (
        input  ll_val,
        input  ll_waddr,
        input  ll_wdata,
        output ll_rdy
    );
endinterface

// File: rtl/parc_core_dpath_wb_arbiter.sv
// Register-file write-port arbiter: W stage has priority, mul/div results
// queue in a FIFO; keeps a pending scoreboard and raises wb_stall on starvation.
// Ports: clk, reset (async, active low), pipe_wen/waddr/wdata (W stage),
// ll (interface slave: val/rdy/waddr/wdata), ll_issue_val/waddr (scoreboard set),
// pending[31:0], wb_stall, wen_p/waddr_p/wdata_p (regfile write port).
module parc_core_dpath_wb_arbiter #(
    parameter int LLQ_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_wen,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    parc_core_dpath_wb_arbiter_if.slave ll,
    input  logic        ll_issue_val,
    input  logic [4:0]  ll_issue_waddr,
    output logic [31:0] pending,
    output logic        wb_stall,
    output logic        wen_p,
    output logic [4:0]  waddr_p,
    output logic [31:0] wdata_p
);

    localparam int PW = (LLQ_DEPTH > 1) ? $clog2(LLQ_DEPTH) : 1;
    localparam int CW = $clog2(LLQ_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_nxt;
    logic          rdy_q, rdy_nxt;
    logic [SW-1:0] starve_q, starve_nxt;
    logic          stall_q, stall_nxt;
    logic [31:0]   pend_q, pend_nxt;

    logic [4:0]    q_addr [LLQ_DEPTH];
    logic [31:0]   q_data [LLQ_DEPTH];

    logic          enq, deq, nonempty, blocked;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    assign nonempty  = (count_q != '0);
    assign enq       = ll.ll_val && rdy_q;
    assign deq       = !pipe_wen && nonempty;
    assign blocked   = pipe_wen && nonempty;
    assign head_addr = q_addr[head_q];
    assign head_data = q_data[head_q];

    assign ll.ll_rdy = rdy_q;
    assign pending   = pend_q;
    assign wb_stall  = stall_q;

    always_comb begin
        wen_p   = 1'b0;
        waddr_p = '0;
        wdata_p = '0;
        unique case (1'b1)
            pipe_wen: begin
                wen_p   = (pipe_waddr != 5'd0);
                waddr_p = pipe_waddr;
                wdata_p = pipe_wdata;
            end
            deq: begin
                wen_p   = (head_addr != 5'd0);
                waddr_p = head_addr;
                wdata_p = head_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        count_nxt = count_q;
        unique case ({enq, deq})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
        // ll_rdy is registered so no path from ll_val reaches it
        rdy_nxt = (count_nxt != CW'(LLQ_DEPTH));
    end

    always_comb begin
        starve_nxt = '0;
        stall_nxt  = 1'b0;
        if (blocked) begin
            if (starve_q == SW'(STARVE_MAX - 1)) begin
                stall_nxt = 1'b1;
            end else begin
                starve_nxt = starve_q + SW'(1);
            end
        end
    end

    // Set after clear: a same-cycle issue is newer than the retiring write
    always_comb begin
        pend_nxt = pend_q;
        if (deq) begin
            pend_nxt[head_addr] = 1'b0;
        end
        if (ll_issue_val && (ll_issue_waddr != 5'd0)) begin
            pend_nxt[ll_issue_waddr] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b1;
            starve_q <= '0;
            stall_q  <= 1'b0;
            pend_q   <= '0;
        end else begin
            if (deq) head_q <= head_q + PW'(1);
            if (enq) tail_q <= tail_q + PW'(1);
            count_q  <= count_nxt;
            rdy_q    <= rdy_nxt;
            starve_q <= starve_nxt;
            stall_q  <= stall_nxt;
            pend_q   <= pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[tail_q] <= ll.ll_waddr;
            q_data[tail_q] <= ll.ll_wdata;
        end
    end

endmodule

// File: tb/tb_parc_core_dpath_wb_arbiter.sv
// Bench for parc_core_dpath_wb_arbiter: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_parc_core_dpath_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_wen;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        iss_val;
    logic [4:0]  iss_waddr;
    logic [31:0] pending;
    logic        wb_stall;
    logic        wen_p;
    logic [4:0]  waddr_p;
    logic [31:0] wdata_p;

    parc_core_dpath_wb_arbiter_if llif ();

    parc_core_dpath_wb_arbiter #(
        .LLQ_DEPTH  (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pipe_wen       (pipe_wen),
        .pipe_waddr     (pipe_waddr),
        .pipe_wdata     (pipe_wdata),
        .ll             (llif),
        .ll_issue_val   (iss_val),
        .ll_issue_waddr (iss_waddr),
        .pending        (pending),
        .wb_stall       (wb_stall),
        .wen_p          (wen_p),
        .waddr_p        (waddr_p),
        .wdata_p        (wdata_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        pw;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        iv;
        logic [4:0]  ia;
        logic        ewen;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic        erdy;
        logic [31:0] epend;
        logic        estall;
    } vec_t;

    ent_t        mq[$];
    logic [31:0] mpend;
    int          mblk;
    logic        mstall;
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        tbl[10];
    logic [31:0] got[$];

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
        n_vec++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, g, e);
        end
    endtask

    task automatic mreset();
        mq.delete();
        mpend  = '0;
        mblk   = 0;
        mstall = 1'b0;
    endtask

    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic iv, input logic [4:0] ia);
        pipe_wen      = pw;
        pipe_waddr    = pa;
        pipe_wdata    = pd;
        llif.ll_val   = lv;
        llif.ll_waddr = la;
        llif.ll_wdata = ld;
        iss_val       = iv;
        iss_waddr     = ia;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Compare every output with the model's view of the current cycle
    task automatic settle();
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        #4;
        ew = 1'b0;
        ea = '0;
        ed = '0;
        if (pipe_wen) begin
            ew = (pipe_waddr != 0);
            ea = pipe_waddr;
            ed = pipe_wdata;
        end else if (mq.size() > 0) begin
            ew = (mq[0].a != 0);
            ea = mq[0].a;
            ed = mq[0].d;
        end
        chk("ll_rdy", 32'(llif.ll_rdy), 32'(mq.size() != DEPTH));
        chk("wen_p", 32'(wen_p), 32'(ew));
        chk("waddr_p", 32'(waddr_p), 32'(ea));
        chk("wdata_p", wdata_p, ed);
        chk("pending", pending, mpend);
        chk("wb_stall", 32'(wb_stall), 32'(mstall));
        if (wb_stall && pipe_wen) begin
            n_bad++;
            $display("FAIL protocol: pipe_wen=1 while wb_stall=1");
        end
    endtask

    task automatic edge_upd();
        logic enq, deq;
        ent_t e;
        @(posedge clk);
        enq = llif.ll_val && (mq.size() != DEPTH);
        deq = !pipe_wen && (mq.size() > 0);
        if (pipe_wen && mq.size() > 0) begin
            mblk++;
            mstall = (mblk == SMAX);
            if (mstall) mblk = 0;
        end else begin
            mblk   = 0;
            mstall = 1'b0;
        end
        if (deq) begin
            e = mq.pop_front();
            mpend[e.a] = 1'b0;
        end
        if (iss_val && iss_waddr != 0) mpend[iss_waddr] = 1'b1;
        mpend[0] = 1'b0;
        if (enq) begin
            e.a = llif.ll_waddr;
            e.d = llif.ll_wdata;
            mq.push_back(e);
        end
        #1;
    endtask

    task automatic tick();
        settle();
        edge_upd();
    endtask

    initial begin
        tbl[0] = '{0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 0, 0};
        tbl[1] = '{0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 32'h20, 0};
        tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 32'h20, 0};
        tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[4] = '{1, 3, 32'h33, 1, 9, 32'h900, 0, 0, 1, 3, 32'h33, 1, 0, 0};
        tbl[5] = '{1, 4, 32'h44, 1, 10, 32'hA00, 0, 0, 1, 4, 32'h44, 1, 0, 0};
        tbl[6] = '{1, 6, 32'h66, 1, 11, 32'hB00, 0, 0, 1, 6, 32'h66, 0, 0, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h900, 0, 0, 0};
        tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 32'hA00, 1, 0, 0};
        tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

        reset = 1'b0;
        idle();
        mreset();
        @(posedge clk);
        #1;
        settle();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].pw, tbl[i].pa, tbl[i].pd, tbl[i].lv, tbl[i].la,
                  tbl[i].ld, tbl[i].iv, tbl[i].ia);
            settle();
            chk($sformatf("tbl%0d_wen", i), 32'(wen_p), 32'(tbl[i].ewen));
            chk($sformatf("tbl%0d_waddr", i), 32'(waddr_p), 32'(tbl[i].ewa));
            chk($sformatf("tbl%0d_wdata", i), wdata_p, tbl[i].ewd);
            chk($sformatf("tbl%0d_rdy", i), 32'(llif.ll_rdy), 32'(tbl[i].erdy));
            chk($sformatf("tbl%0d_pend", i), pending, tbl[i].epend);
            chk($sformatf("tbl%0d_stall", i), 32'(wb_stall), 32'(tbl[i].estall));
            edge_upd();
        end

        // Starvation: one entry blocked for SMAX cycles
        drive(0, 0, 0, 1, 12, 32'hCC, 1, 12);
        tick();
        for (int i = 0; i < SMAX; i++) begin
            drive(1, 1, 32'(i), 0, 0, 0, 0, 0);
            settle();
            chk("starve_no_stall", 32'(wb_stall), 0);
            edge_upd();
        end
        idle();
        settle();
        chk("starve_stall", 32'(wb_stall), 1);
        chk("starve_wen", 32'(wen_p), 1);
        chk("starve_waddr", 32'(waddr_p), 12);
        chk("starve_wdata", wdata_p, 32'hCC);
        edge_upd();
        settle();
        chk("starve_clear", 32'(wb_stall), 0);
        chk("starve_pend", pending, 0);
        edge_upd();

        // Issue of r7 in the same cycle as the retiring r7 write
        drive(0, 0, 0, 1, 7, 32'h77, 1, 7);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 7);
        settle();
        chk("setwin_waddr", 32'(waddr_p), 7);
        edge_upd();
        idle();
        settle();
        chk("setwin_pend7", 32'(pending[7]), 1);
        edge_upd();

        // Writes to r0 from both sources
        drive(1, 0, 32'h55, 1, 0, 32'hAA, 1, 0);
        settle();
        chk("r0_pipe_wen", 32'(wen_p), 0);
        edge_upd();
        idle();
        settle();
        chk("r0_ll_wen", 32'(wen_p), 0);
        chk("r0_ll_wdata", wdata_p, 32'hAA);
        chk("r0_pend0", 32'(pending[0]), 0);
        edge_upd();
        tick();

        // Back-to-back transfers with dequeues: pointer wrap
        got.delete();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1, 5'(i + 1), 32'h1000 + 32'(i), 0, 0);
            settle();
            if (wen_p) got.push_back(wdata_p);
            edge_upd();
        end
        idle();
        settle();
        if (wen_p) got.push_back(wdata_p);
        edge_upd();
        chk("wrap_count", 32'(got.size()), 10);
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            chk($sformatf("wrap%0d", i), got[i], 32'h1000 + 32'(i));
        end

        // Asynchronous reset with two queued entries
        drive(1, 2, 32'h2, 1, 20, 32'h20, 1, 20);
        tick();
        drive(1, 3, 32'h3, 1, 21, 32'h21, 1, 21);
        tick();
        idle();
        #1;
        chk("prerst_pend", pending, 32'h0030_0000);
        chk("prerst_rdy", 32'(llif.ll_rdy), 0);
        reset = 1'b0;
        #1;
        chk("rst_rdy", 32'(llif.ll_rdy), 1);
        chk("rst_pend", pending, 0);
        chk("rst_wen", 32'(wen_p), 0);
        chk("rst_stall", 32'(wb_stall), 0);
        mreset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic pw;
            pw = ($urandom_range(0, 2) != 0);
            if (mstall) pw = 1'b0;
            drive(pw, 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
